mdr_unit: RTL and testbench

Parametrised memory data register for the datapath. It sits between the internal bus and the memory port, and it can load from the bus directly. It runs its own request/acknowledge handshake with memory, with a timeout. Loads support byte, halfword, word and full-width sizes with sign or zero extension. Stores replicate lanes and drive byte enables.

---
 rtl/mdr_unit.sv | 188 ++++++++++++++++++
 tb/tb_mdr_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_unit.sv
// Memory data register: bus load, sized/extended memory reads, lane-replicated
// stores with byte enables, and a req/ack handshake bounded by a timeout.
module mdr_unit #(
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned TIMEOUT = 15,
  localparam int unsigned LANE_W  = $clog2(DATA_W / 8)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [DATA_W-1:0]     BusMuxOut,
  input  logic                  MDRin,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [LANE_W-1:0]     addr_lo,
  input  logic [DATA_W-1:0]     Mdatain,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     Mdataout,
  output logic [DATA_W-1:0]     Q,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [1:0]          size_q, size_d;
  logic                sext_q, sext_d;
  logic [LANE_W-1:0]   addr_q, addr_d;
  logic [1:0]          eff_s;

  // log2 of the access byte count; "full" collapses to "word" on a 32-bit datapath
  function automatic logic [1:0] eff_size(input logic [1:0] s);
    return (DATA_W == 32 && s == 2'b11) ? 2'b10 : s;
  endfunction

  function automatic logic [LANE_W-1:0] lane_off(input logic [1:0] s,
                                                 input logic [LANE_W-1:0] a);
    logic [LANE_W-1:0] m;
    m = '1;
    m = m << s;
    return a & m;
  endfunction

  function automatic logic [BE_W-1:0] lane_be(input logic [1:0] s,
                                              input logic [LANE_W-1:0] a);
    logic [BE_W-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < BE_W; i++)
      if (i < (32'd1 << s)) b[i] = 1'b1;
    return b << lane_off(s, a);
  endfunction

  function automatic logic [DATA_W-1:0] replicate(input logic [1:0] s,
                                                  input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BE_W; i++)
      r[8*i +: 8] = d[8*(i & ((32'd1 << s) - 32'd1)) +: 8];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] load(input logic [1:0] s, input logic sx,
                                             input logic [LANE_W-1:0] a,
                                             input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] sh, r;
    int unsigned       n;
    logic              neg;
    sh  = d >> {lane_off(s, a), 3'b000};
    n   = 32'd1 << s;
    neg = sx & sh[8*n-1];
    r   = '0;
    for (int unsigned i = 0; i < BE_W; i++)
      r[8*i +: 8] = (i < n) ? sh[8*i +: 8] : {8{neg}};
    return r;
  endfunction

  // Next-state: command acceptance in IDLE, ack/timeout resolution while busy
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    dout_d  = dout_q;
    be_d    = be_q;
    req_d   = req_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    eff_s   = eff_size(size);
    unique case (state_q)
      S_IDLE: begin
        if (Read || Write) begin
          state_d = Read ? S_READ : S_WRITE;
          size_d  = eff_s;
          sext_d  = sign_ext;
          addr_d  = addr_lo;
          cnt_d   = '0;
          err_d   = 1'b0;
          req_d   = 1'b1;
          we_d    = !Read;
          busy_d  = 1'b1;
          be_d    = lane_be(eff_s, addr_lo);
          dout_d  = replicate(eff_s, q_q);
        end else if (MDRin) begin
          q_d = BusMuxOut;
        end
      end
      default: begin
        // ack takes precedence over a timeout landing on the same edge
        if (mem_ack || cnt_q == 8'(TIMEOUT - 1)) begin
          if (mem_ack && state_q == S_READ)
            q_d = load(size_q, sext_q, addr_q, Mdatain);
          err_d   = !mem_ack;
          state_d = S_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  // State and registered outputs with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      dout_q  <= '0;
      be_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      dout_q  <= dout_d;
      be_q    <= be_d;
      req_q   <= req_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
    end
  end

  assign mem_req  = req_q;
  assign mem_we   = we_q;
  assign mem_be   = be_q;
  assign Mdataout = dout_q;
  assign Q        = q_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mdr_unit.sv
// Runs a 32-bit and a 64-bit mdr_unit in lockstep from shared stimulus and
// checks both against a byte-arithmetic reference model.
module tb_mdr_unit;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, MDRin, Read, Write, sign_ext, mem_ack;
  logic [1:0]  size;
  logic [2:0]  addr_lo;
  logic [63:0] bus, mdin;

  logic        req32, we32, busy32, done32, err32;
  logic [3:0]  be32;
  logic [31:0] dout32, q32;
  logic        req64, we64, busy64, done64, err64;
  logic [7:0]  be64;
  logic [63:0] dout64, q64;

  mdr_unit #(.DATA_W(32), .TIMEOUT(TO)) u32 (
    .clk(clk), .clr(clr), .BusMuxOut(bus[31:0]), .MDRin(MDRin), .Read(Read),
    .Write(Write), .size(size), .sign_ext(sign_ext), .addr_lo(addr_lo[1:0]),
    .Mdatain(mdin[31:0]), .mem_ack(mem_ack), .mem_req(req32), .mem_we(we32),
    .mem_be(be32), .Mdataout(dout32), .Q(q32), .busy(busy32), .done(done32),
    .err(err32));

  mdr_unit #(.DATA_W(64), .TIMEOUT(TO)) u64 (
    .clk(clk), .clr(clr), .BusMuxOut(bus), .MDRin(MDRin), .Read(Read),
    .Write(Write), .size(size), .sign_ext(sign_ext), .addr_lo(addr_lo),
    .Mdatain(mdin), .mem_ack(mem_ack), .mem_req(req64), .mem_we(we64),
    .mem_be(be64), .Mdataout(dout64), .Q(q64), .busy(busy64), .done(done64),
    .err(err64));

  int          total = 0;
  int          bad   = 0;
  logic [63:0] mq32, mq64;
  logic        merr;

  function automatic int unsigned nbytes(int unsigned w, logic [1:0] s);
    if (s == 2'd3 || (w == 32 && s == 2'd2)) return w / 8;
    return 1 << s;
  endfunction

  function automatic int unsigned offs(int unsigned w, logic [1:0] s, logic [2:0] a);
    int unsigned n = nbytes(w, s);
    return ((int'(a) % (w / 8)) / n) * n;
  endfunction

  function automatic logic [63:0] bmask(int unsigned n);
    if (n == 8) return '1;
    return (64'd1 << (8 * n)) - 64'd1;
  endfunction

  function automatic logic [63:0] m_load(int unsigned w, logic [1:0] s, logic sx,
                                         logic [2:0] a, logic [63:0] d);
    int unsigned n = nbytes(w, s);
    logic [63:0] v;
    v = (d >> (8 * offs(w, s, a))) & bmask(n);
    if (sx && v[8*n-1]) v = v | ~bmask(n);
    if (w == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  function automatic logic [63:0] m_be(int unsigned w, logic [1:0] s, logic [2:0] a);
    return ((64'd1 << nbytes(w, s)) - 64'd1) << offs(w, s, a);
  endfunction

  function automatic logic [63:0] m_rep(int unsigned w, logic [1:0] s, logic [63:0] q);
    int unsigned n = nbytes(w, s);
    logic [63:0] r = '0;
    for (int unsigned k = 0; k < w / (8 * n); k++)
      r = r | ((q & bmask(n)) << (8 * n * k));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ereq, input logic ebusy,
                         input logic edone);
    chk({tag, ".req32"}, 64'(req32), 64'(ereq));
    chk({tag, ".req64"}, 64'(req64), 64'(ereq));
    chk({tag, ".busy32"}, 64'(busy32), 64'(ebusy));
    chk({tag, ".busy64"}, 64'(busy64), 64'(ebusy));
    chk({tag, ".done32"}, 64'(done32), 64'(edone));
    chk({tag, ".done64"}, 64'(done64), 64'(edone));
    chk({tag, ".err32"}, 64'(err32), 64'(merr));
    chk({tag, ".err64"}, 64'(err64), 64'(merr));
    chk({tag, ".q32"}, 64'(q32), mq32);
    chk({tag, ".q64"}, q64, mq64);
  endtask

  // Caller sits at a negedge; returns at the negedge where done is expected high.
  // dly = wait cycles before ack; dly >= TO means no ack (timeout).
  task automatic access(input bit rd, input logic [1:0] s, input logic sx,
                        input logic [2:0] a, input logic [63:0] md,
                        input int unsigned dly, input bit poke);
    logic [63:0] ebe32, ebe64, edo32, edo64;
    int unsigned reqc = 0;
    bit fin = 0;
    Read = rd; Write = !rd; size = s; sign_ext = sx; addr_lo = a; mdin = md;
    mem_ack = 1'b0;
    ebe32 = m_be(32, s, a);  ebe64 = m_be(64, s, a);
    edo32 = m_rep(32, s, mq32); edo64 = m_rep(64, s, mq64);
    merr = 1'b0;
    @(negedge clk);
    Read = 1'b0; Write = 1'b0; MDRin = 1'b0;
    for (int unsigned c = 0; c < TO + 2 && !fin; c++) begin
      chk("wait", {req32, req64, we32, we64, busy32, busy64, done32, done64},
          {1'b1, 1'b1, !rd, !rd, 1'b1, 1'b1, 1'b0, 1'b0});
      chk("be32", 64'(be32), ebe32);
      chk("be64", 64'(be64), ebe64);
      if (!rd) begin
        chk("dout32", 64'(dout32), edo32);
        chk("dout64", dout64, edo64);
      end
      reqc += int'(req32) + int'(req64);
      if (poke) begin
        MDRin = 1'b1; Read = 1'b1; Write = 1'b1;
        bus = {$urandom, $urandom};
      end
      mem_ack = (c == dly);
      @(negedge clk);
      mem_ack = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0;
      if (c == dly) begin
        fin = 1;
        if (rd) begin
          mq32 = m_load(32, s, sx, a, md);
          mq64 = m_load(64, s, sx, a, md);
        end
      end else if (c == TO - 1) begin
        fin = 1;
        merr = 1'b1;
      end
    end
    chk_all("end", 1'b0, 1'b0, 1'b1);
    chk("reqcycles", 64'(reqc), 64'(2 * ((dly < TO) ? dly + 1 : TO)));
  endtask

  task automatic idle();
    @(negedge clk);
    chk_all("idle", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mdr_load(input logic [63:0] v);
    MDRin = 1'b1; bus = v;
    @(negedge clk);
    MDRin = 1'b0;
    mq32 = v & 64'hFFFF_FFFF; mq64 = v;
    chk_all("load", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    clr = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0; sign_ext = 1'b0;
    mem_ack = 1'b0; size = '0; addr_lo = '0; bus = '0; mdin = '0;
    mq32 = '0; mq64 = '0; merr = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.we", {we32, we64, be32, be64}, '0);
    chk("reset.dout", 64'(dout32) | dout64, '0);
    clr = 1'b1;

    mdr_load(64'h0123_4567_DEAD_BEEF);
    chk("load.dead", 64'(q32), 64'hDEAD_BEEF);

    access(1'b1, 2'd0, 1'b1, 3'd2, 64'h9ABC_DEF0_12F4_5678, 0, 1'b0);
    chk("sbyte.q", 64'(q32), 64'hFFFF_FFF4);
    idle();
    access(1'b1, 2'd0, 1'b0, 3'd2, 64'h9ABC_DEF0_12F4_5678, 0, 1'b0);
    chk("zbyte.q", 64'(q32), 64'h0000_00F4);
    idle();

    mdr_load(64'h0000_0000_0000_ABCD);
    access(1'b0, 2'd1, 1'b0, 3'd3, {$urandom, $urandom}, 0, 1'b0);
    chk("hstore.q", 64'(q32), 64'h0000_ABCD);
    idle();

    access(1'b1, 2'd2, 1'b0, 3'd1, {$urandom, $urandom}, TO, 1'b0);
    idle();
    access(1'b1, 2'd1, 1'b1, 3'd6, {$urandom, $urandom}, 1, 1'b0);
    idle();

    MDRin = 1'b1; bus = 64'h5555_5555_5555_5555;
    access(1'b1, 2'd2, 1'b0, 3'd0, 64'hCAFE_F00D_8765_4321, 0, 1'b0);
    idle();

    access(1'b1, 2'd1, 1'b1, 3'd0, {$urandom, $urandom}, TO - 1, 1'b0);
    idle();
    access(1'b0, 2'd2, 1'b0, 3'd0, {$urandom, $urandom}, 2, 1'b1);
    access(1'b1, 2'd0, 1'b1, 3'd1, {$urandom, $urandom}, 1, 1'b1);
    access(1'b1, 2'd3, 1'b0, 3'd5, {$urandom, $urandom}, 0, 1'b0);
    chk("dword.be64", 64'(be64), 64'hFF);
    idle();

    Read = 1'b1; size = 2'd0; addr_lo = 3'd0;
    @(negedge clk);
    Read = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1; mq32 = '0; mq64 = '0; merr = 1'b0;
    chk_all("midreset", 1'b0, 1'b0, 1'b0);
    mem_ack = 1'b1; mdin = '1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk_all("strayack", 1'b0, 1'b0, 1'b0);
    idle();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0)
        mdr_load({$urandom, $urandom});
      else
        access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               {$urandom, $urandom}, $urandom_range(0, TO), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
